brs_uart_rx: RTL and testbench

Serial receive front end that sits directly upstream of the BRS core inside tt_um_BRS_2. It takes the asynchronous 8N1 serial line from a dedicated input pin and deserialises it into bytes. Each byte is presented to the core over a one-entry valid/ready holding register. Framing errors and overruns are reported to the core as status flags.

---
 rtl/brs_uart_rx.sv | 157 +++++++++++++++
 tb/tb_brs_uart_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/brs_uart_rx.sv
// brs_uart_rx: 8N1 serial receiver feeding the BRS core.
// Synchronises the raw line, finds each bit centre with a down-counter,
// deserialises LSB first and hands bytes over a one-entry valid/ready
// holding register. Reports framing errors and dropped bytes (overrun).
module brs_uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       ovr_clr
);

  // Half a bit gets us from the start edge to the start-bit centre,
  // a full bit steps from one centre to the next.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic [1:0]       sync_reg;
  logic             rxd_s;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             frame_err_reg, frame_err_next;
  logic             byte_done;
  logic [7:0]       rx_data_reg;
  logic             rx_valid_reg;
  logic             overrun_reg;

  assign rxd_s = sync_reg[1];

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= 2'b11;
    else     sync_reg <= {sync_reg[0], rxd};
  end

  // Receiver state, bit timer, bit index, shifter and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Next-state logic; every decision is taken at a bit centre (cnt = 0).
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    byte_done      = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!rxd_s) begin
          cnt_next   = CNT_HALF;
          state_next = S_START;
        end
      end
      S_START: begin
        if (cnt_reg == '0) begin
          if (!rxd_s) begin
            cnt_next     = CNT_FULL;
            bit_idx_next = 3'd0;
            state_next   = S_DATA;
          end else begin
            // Line went back high before mid-bit: treat as noise.
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_reg == '0) begin
          shift_next = {rxd_s, shift_reg[7:1]};
          cnt_next   = CNT_FULL;
          if (bit_idx_reg == 3'd7) state_next = S_STOP;
          else                     bit_idx_next = bit_idx_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_reg == '0) begin
          // Leave at the stop-bit centre so an immediately following
          // start bit is still seen from IDLE.
          if (rxd_s) begin
            byte_done  = 1'b1;
            state_next = S_IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = S_WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        // A held-low (break) line must not be decoded as new frames.
        if (rxd_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // One-entry holding register with overrun tracking; a set beats ovr_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_reg  <= 8'h00;
      rx_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      if (byte_done) begin
        if (!rx_valid_reg || rx_ready) begin
          rx_data_reg  <= shift_reg;
          rx_valid_reg <= 1'b1;
        end
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
      if (byte_done && rx_valid_reg && !rx_ready) overrun_reg <= 1'b1;
      else if (ovr_clr)                           overrun_reg <= 1'b0;
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_brs_uart_rx.sv
// Directed testbench for brs_uart_rx with CLKS_PER_BIT = 8.
module tb_brs_uart_rx;

  localparam int CPB = 8;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       ovr_clr;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int start_cyc = 0;
  int valid_rise_cyc = 0;
  int fe_cycles = 0;
  int valid_cycles = 0;
  logic prev_valid = 1'b0;
  logic [7:0] acc_q[$];

  brs_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive observer: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cycles = fe_cycles + 1;
      if (rx_valid) valid_cycles = valid_cycles + 1;
      if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
    end
    prev_valid = rx_valid;
  end

  // Caller must be at posedge+2; returns at posedge+2 with rxd left at stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    #2;
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(posedge clk);
      #2;
    end
    rxd = stop;
    repeat (CPB) @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; rx_ready = 1'b0; ovr_clr = 1'b0;
    idle(3);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rx_data); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", overrun); end
    rst = 1'b0;
    idle(5);
    $display("test_reset: valid=%b data=%h", rx_valid, rx_data);
  endtask

  task automatic test_single();
    int lat;
    valid_rise_cyc = 0;
    send_frame(8'hA5, 1'b1);
    idle(2);
    lat = valid_rise_cyc - start_cyc;
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", rx_valid); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", rx_data); end
    total++; if (lat < 77 || lat > 80) begin bad++; $display("FAIL single_latency got=%0d want=77..80", lat); end
    consume();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL single_consume got=%b want=0", rx_valid); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL single_hold got=%h want=a5", rx_data); end
    $display("test_single: byte=%h latency=%0d", rx_data, lat);
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cycles;
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(100);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b want=0", rx_valid); end
    total++; if (fe_cycles - fe0 !== 0) begin bad++; $display("FAIL glitch_ferr got=%0d want=0", fe_cycles - fe0); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL glitch_ovr got=%b want=0", overrun); end
    send_frame(8'h3C, 1'b1);
    idle(2);
    total++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin bad++; $display("FAIL glitch_next got=%b/%h want=1/3c", rx_valid, rx_data); end
    consume();
    $display("test_glitch: next byte=%h", rx_data);
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cycles;
    send_frame(8'h81, 1'b0);
    idle(40);
    rxd = 1'b1;
    idle(20);
    total++; if (fe_cycles - fe0 !== 1) begin bad++; $display("FAIL ferr_pulse got=%0d want=1", fe_cycles - fe0); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ferr_valid got=%b want=0", rx_valid); end
    send_frame(8'h55, 1'b1);
    idle(2);
    total++; if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin bad++; $display("FAIL ferr_next got=%b/%h want=1/55", rx_valid, rx_data); end
    consume();
    $display("test_frame_err: pulses=%0d next byte=%h", fe_cycles - fe0, rx_data);
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(2);
    total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL ovr_data got=%h want=11", rx_data); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", overrun); end
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr got=%b want=0", overrun); end
    total++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin bad++; $display("FAIL ovr_hold got=%b/%h want=1/11", rx_valid, rx_data); end
    consume();
    $display("test_overrun: kept=%h", 8'h11);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h5A; exp[3] = 8'hC3;
    acc_q.delete();
    valid_cycles = 0;
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(exp[i], 1'b1);
    idle(20);
    total++; if (acc_q.size() !== 4) begin bad++; $display("FAIL stream_count got=%0d want=4", acc_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < acc_q.size()) begin
        total++; if (acc_q[i] !== exp[i]) begin bad++; $display("FAIL stream_byte%0d got=%h want=%h", i, acc_q[i], exp[i]); end
      end
    end
    total++; if (valid_cycles !== 4) begin bad++; $display("FAIL stream_valid_cycles got=%0d want=4", valid_cycles); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL stream_ovr got=%b want=0", overrun); end
    $display("test_back_to_back: received=%0d bytes", acc_q.size());
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int fe0;
    d = 8'h96;
    acc_q.delete();
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      idle(CPB);
    end
    rxd = d[4];
    idle(4);
    rst = 1'b1;
    idle(3);
    total++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin bad++; $display("FAIL midrst_out got=%b/%h want=0/00", rx_valid, rx_data); end
    total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL midrst_flags got=%b/%b want=0/0", frame_err, overrun); end
    rst = 1'b0;
    fe0 = fe_cycles;
    rxd = 1'b1;
    idle(20);
    send_frame(8'h4B, 1'b1);
    idle(20);
    total++; if (acc_q.size() !== 1) begin bad++; $display("FAIL midrst_count got=%0d want=1", acc_q.size()); end
    if (acc_q.size() > 0) begin
      total++; if (acc_q[0] !== 8'h4B) begin bad++; $display("FAIL midrst_byte got=%h want=4b", acc_q[0]); end
    end
    total++; if (fe_cycles - fe0 !== 0) begin bad++; $display("FAIL midrst_ferr got=%0d want=0", fe_cycles - fe0); end
    rx_ready = 1'b0;
    $display("test_reset_mid_frame: delivered=%0d", acc_q.size());
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; rx_ready = 1'b0; ovr_clr = 1'b0;
    @(posedge clk);
    #2;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
